// File: rtl/store_write_buffer_if.sv
// Store-port and memory-side signal bundle for store_write_buffer.
// The slave modport is the buffer itself; STORE_WB_FORWARD_EN adds the load-forwarding signals.
interface store_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic                    MemWrite;
  logic [AW-1:0]           DataAdr;
  logic [DW-1:0]           WriteData;
  logic                    stall;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    align_err;
  logic                    mem_valid;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic                    mem_ready;
`ifdef STORE_WB_FORWARD_EN
  logic [AW-1:0]           ld_addr;
  logic                    fwd_hit;
  logic [DW-1:0]           fwd_data;

  modport master (
    output MemWrite, DataAdr, WriteData, mem_ready, ld_addr,
    input  stall, empty, count, align_err, mem_valid, mem_addr, mem_wdata, fwd_hit, fwd_data
  );
  modport slave (
    input  MemWrite, DataAdr, WriteData, mem_ready, ld_addr,
    output stall, empty, count, align_err, mem_valid, mem_addr, mem_wdata, fwd_hit, fwd_data
  );
`else
  modport master (
    output MemWrite, DataAdr, WriteData, mem_ready,
    input  stall, empty, count, align_err, mem_valid, mem_addr, mem_wdata
  );
  modport slave (
    input  MemWrite, DataAdr, WriteData, mem_ready,
    output stall, empty, count, align_err, mem_valid, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/store_write_buffer.sv
// Posted store FIFO: one-cycle capture, store visible to memory after its accepting edge; stalls core when full.
// Optional STORE_WB_FORWARD_EN adds a combinational youngest-match load forward over buffered entries.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addrMem [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] occ;
  logic          alignErr;

  logic full;
  logic misaligned;
  logic accept;
  logic doEnq;
  logic doDeq;

  // Full comes only from registered occupancy, so a same-cycle drain never frees a slot early.
  assign full       = (occ == CW'(DEPTH));
  assign misaligned = (bus.DataAdr[1:0] != 2'b00);
  assign accept     = bus.MemWrite && !full;
  assign doEnq      = accept && !misaligned;
  assign doDeq      = (occ != '0) && bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      occ      <= '0;
      alignErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addrMem[i] <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      if (doEnq) begin
        addrMem[wrPtr] <= bus.DataAdr;
        dataMem[wrPtr] <= bus.WriteData;
        wrPtr          <= wrPtr + PW'(1);
      end
      if (doDeq) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (accept && misaligned) begin
        alignErr <= 1'b1;
      end
      if (doEnq && !doDeq) begin
        occ <= occ + CW'(1);
      end else if (!doEnq && doDeq) begin
        occ <= occ - CW'(1);
      end
    end
  end

  assign bus.mem_valid = (occ != '0);
  assign bus.mem_addr  = addrMem[rdPtr];
  assign bus.mem_wdata = dataMem[rdPtr];
  assign bus.stall     = full;
  assign bus.empty     = (occ == '0);
  assign bus.count     = occ;
  assign bus.align_err = alignErr;

`ifdef STORE_WB_FORWARD_EN
  logic [AW-1:0] ldWord;
  logic [PW-1:0] scanIdx;
  logic          fwdHit;
  logic [DW-1:0] fwdData;

  assign ldWord = bus.ld_addr & ~AW'(3);

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    scanIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = rdPtr + PW'(i);
      if ((CW'(i) < occ) && (addrMem[scanIdx] == ldWord)) begin
        fwdHit  = 1'b1;
        fwdData = dataMem[scanIdx];
      end
    end
  end

  assign bus.fwd_hit  = fwdHit;
  assign bus.fwd_data = fwdData;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: expected stores queued at drive time, checked at each memory handshake.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk;
  logic reset;
  int   passCnt  = 0;
  int   totalCnt = 0;
  logic [AW+DW-1:0] sbQ [$];

  store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (reset && bus.mem_valid && bus.mem_ready) begin
      totalCnt++;
      if (sbQ.size() == 0) begin
        $display("FAIL unexpected_write got addr=%h data=%h required no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [AW+DW-1:0] exp;
        exp = sbQ.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp)
          $display("FAIL drain_order got addr=%h data=%h required addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
        else
          passCnt++;
      end
    end
  end

  task automatic drive(input logic mw, input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic rdy);
    @(posedge clk);
    #1;
    bus.MemWrite  = mw;
    bus.DataAdr   = adr;
    bus.WriteData = dat;
    bus.mem_ready = rdy;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
    bus.mem_ready = 1'b0;
`ifdef STORE_WB_FORWARD_EN
    bus.ld_addr   = '0;
`endif
    #12;
    totalCnt++;
    if ({bus.mem_valid, bus.stall, bus.empty, bus.align_err} !== 4'b0010)
      $display("FAIL reset_flags got valid/stall/empty/err=%b required 0010",
               {bus.mem_valid, bus.stall, bus.empty, bus.align_err});
    else passCnt++;
    totalCnt++;
    if (bus.count !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0)
      $display("FAIL reset_values got count=%0d addr=%h data=%h required 0/0/0", bus.count, bus.mem_addr, bus.mem_wdata);
    else passCnt++;
    #10;
    reset = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 32'h64, 32'd7, 1'b1);
    sbQ.push_back({32'h64, 32'd7});
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    totalCnt++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h64 || bus.mem_wdata !== 32'd7)
      $display("FAIL single_out got valid=%b addr=%h data=%0d required 1/64/7", bus.mem_valid, bus.mem_addr, bus.mem_wdata);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (bus.empty !== 1'b1 || bus.count !== '0)
      $display("FAIL single_empty got empty=%b count=%0d required 1/0", bus.empty, bus.count);
    else passCnt++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'(i + 1), 1'b0);
      sbQ.push_back({32'(4 * i), 32'(i + 1)});
    end
    drive(1'b1, 32'h10, 32'd5, 1'b0);
    @(negedge clk);
    totalCnt++;
    if (bus.count !== 3'd4 || bus.stall !== 1'b1)
      $display("FAIL fill_full got count=%0d stall=%b required 4/1", bus.count, bus.stall);
    else passCnt++;
    drive(1'b1, 32'h10, 32'd5, 1'b1);
    @(negedge clk);
    totalCnt++;
    if (bus.count !== 3'd4 || bus.stall !== 1'b1)
      $display("FAIL fill_reject got count=%0d stall=%b required 4/1", bus.count, bus.stall);
    else passCnt++;
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    totalCnt++;
    if (bus.count !== 3'd3 || bus.stall !== 1'b0)
      $display("FAIL fill_unstall got count=%0d stall=%b required 3/0", bus.count, bus.stall);
    else passCnt++;
    for (int n = 0; n < 40 && sbQ.size() != 0; n++) @(negedge clk);
    totalCnt++;
    if (sbQ.size() != 0) $display("FAIL fill_drain_timeout got pending=%0d required 0", sbQ.size());
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h100, 32'hA0, 1'b0);
    sbQ.push_back({32'h100, 32'hA0});
    drive(1'b1, 32'h104, 32'hA1, 1'b0);
    sbQ.push_back({32'h104, 32'hA1});
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h108 + 32'(4 * i), 32'hA2 + 32'(i), 1'b1);
      sbQ.push_back({32'h108 + 32'(4 * i), 32'hA2 + 32'(i)});
      @(negedge clk);
      totalCnt++;
      if (bus.count !== 3'd2)
        $display("FAIL b2b_count cycle=%0d got count=%0d required 2", i, bus.count);
      else passCnt++;
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int n = 0; n < 40 && sbQ.size() != 0; n++) @(negedge clk);
    totalCnt++;
    if (sbQ.size() != 0) $display("FAIL b2b_drain_timeout got pending=%0d required 0", sbQ.size());
    else passCnt++;
  endtask

`ifdef STORE_WB_FORWARD_EN
  task automatic test_forward();
    bus.ld_addr = 32'h21;
    drive(1'b1, 32'h20, 32'd5, 1'b0);
    sbQ.push_back({32'h20, 32'd5});
    @(negedge clk);
    totalCnt++;
    if (bus.fwd_hit !== 1'b0)
      $display("FAIL fwd_same_cycle got hit=%b required 0", bus.fwd_hit);
    else passCnt++;
    drive(1'b1, 32'h20, 32'd6, 1'b0);
    sbQ.push_back({32'h20, 32'd6});
    @(negedge clk);
    totalCnt++;
    if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd5)
      $display("FAIL fwd_first got hit=%b data=%0d required 1/5", bus.fwd_hit, bus.fwd_data);
    else passCnt++;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    totalCnt++;
    if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd6)
      $display("FAIL fwd_youngest got hit=%b data=%0d required 1/6", bus.fwd_hit, bus.fwd_data);
    else passCnt++;
    bus.ld_addr = 32'h40;
    #1;
    totalCnt++;
    if (bus.fwd_hit !== 1'b0)
      $display("FAIL fwd_miss got hit=%b required 0", bus.fwd_hit);
    else passCnt++;
    drive(1'b0, '0, '0, 1'b1);
    for (int n = 0; n < 40 && sbQ.size() != 0; n++) @(negedge clk);
    totalCnt++;
    if (sbQ.size() != 0) $display("FAIL fwd_drain_timeout got pending=%0d required 0", sbQ.size());
    else passCnt++;
  endtask
`endif

  task automatic test_misaligned();
    drive(1'b1, 32'h66, 32'd9, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    totalCnt++;
    if (bus.count !== '0 || bus.align_err !== 1'b1 || bus.mem_valid !== 1'b0)
      $display("FAIL misaligned got count=%0d err=%b valid=%b required 0/1/0", bus.count, bus.align_err, bus.mem_valid);
    else passCnt++;
    drive(1'b1, 32'h68, 32'hB, 1'b1);
    sbQ.push_back({32'h68, 32'hB});
    drive(1'b0, '0, '0, 1'b1);
    for (int n = 0; n < 40 && sbQ.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    totalCnt++;
    if (bus.align_err !== 1'b1 || sbQ.size() != 0)
      $display("FAIL align_sticky got err=%b pending=%0d required 1/0", bus.align_err, sbQ.size());
    else passCnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h200 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    totalCnt++;
    if (bus.count !== 3'd3)
      $display("FAIL mid_pending got count=%0d required 3", bus.count);
    else passCnt++;
    #2;
    reset = 1'b0;
    #1;
    totalCnt++;
    if ({bus.mem_valid, bus.stall, bus.empty, bus.align_err} !== 4'b0010 || bus.count !== '0)
      $display("FAIL mid_reset got valid/stall/empty/err=%b count=%0d required 0010/0",
               {bus.mem_valid, bus.stall, bus.empty, bus.align_err}, bus.count);
    else passCnt++;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    repeat (4) @(negedge clk);
    totalCnt++;
    if (bus.empty !== 1'b1 || bus.mem_valid !== 1'b0)
      $display("FAIL mid_dropped got empty=%b valid=%b required 1/0", bus.empty, bus.mem_valid);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
`ifdef STORE_WB_FORWARD_EN
    test_forward();
`endif
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
